clock_set_ctrl: RTL and testbench

Time-of-day controller for the digital-clock datapath. It does three things:
- Divides clk down to a 1 Hz tick.
- Sequences the cascaded BCD digit counters (sec mod 10/6, min mod 10/6, hours mod 24) with ripple carries.
- Runs a button-driven set-mode FSM that lets the user adjust hours and minutes.

Outputs feed the 7-segment display driver.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/bcd_digit_cnt.sv | 43 ++++
 rtl/clock_set_ctrl.sv | 130 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    typedef logic [3:0] bcd_t;

    // Units digits count 0-9, tens-of-sec/min count 0-5.
    localparam bcd_t SEC_LO_MAX     = 4'd9;
    localparam bcd_t SEC_HI_MAX     = 4'd5;
    // Hours stop at 23: tens digit 2, and units 3 while the tens digit is 2.
    localparam bcd_t HR_MAX_HI      = 4'd2;
    localparam bcd_t HR_MAX_LO_AT_2 = 4'd3;

    // Set-mode button cycles RUN -> SET_HR -> SET_MIN -> RUN.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counter, modulo MAX+1, with synchronous clear and carry out.
module bcd_digit_cnt
    import clock_pkg::*;
#(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] value,
    output logic       co
);

    bcd_t value_q;
    bcd_t value_d;

    // Next value: clear wins, otherwise advance and wrap at MAX when enabled.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (en) begin
            // >= rather than == so a corrupted digit still recovers to a legal value.
            value_d = (value_q >= MAX) ? '0 : value_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign co    = en && (value_q == MAX);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: 1 Hz prescaler, cascaded BCD time digits and a
// button-driven set-mode FSM (RUN / SET_HR / SET_MIN).
// Optional macro CLOCK_SET_BLINK_EN enables a 1 Hz, 50% duty blink strobe
// for the field being edited; without it blink is tied low.
// TICK_DIV must be even and >= 4, and 2**CNT_W >= TICK_DIV.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       tick_1hz,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    mode_t            mode_q,  mode_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick_q,  tick_d;

    logic run_tick;
    logic inc_hr;
    logic inc_min;
    logic sec_clr;
    logic min_lo_en;
    logic hr_lo_en;
    logic hr_clr;

    logic sec_lo_co, sec_hi_co, min_lo_co, min_hi_co, hr_lo_co, hr_hi_co;

    // Mode next-state and per-digit control strobes.
    always_comb begin
        mode_d = mode_q;
        if (btn_mode) begin
            mode_d = next_mode(mode_q);
        end
        // A tick in RUN is applied even when btn_mode arrives on the same edge.
        run_tick = (mode_q == RUN) && tick_q;
        // A simultaneous btn_mode takes priority and the increment is dropped.
        inc_hr   = (mode_q == SET_HR)  && btn_inc && !btn_mode;
        inc_min  = (mode_q == SET_MIN) && btn_inc && !btn_mode;
        // Leaving SET_MIN restarts the second from zero.
        sec_clr  = (mode_q == SET_MIN) && btn_mode;

        min_lo_en = sec_hi_co || inc_min;
        // Minute rollover feeds hours only while running; set-mode wraps stay local.
        hr_lo_en  = (min_hi_co && (mode_q == RUN)) || inc_hr;
        // 23 -> 00 on increment; hr_hi_co only fires from an illegal 29 and
        // is folded in so hours self-correct.
        hr_clr    = (hr_lo_en && (hr_hi == HR_MAX_HI) && (hr_lo == HR_MAX_LO_AT_2))
                    || hr_hi_co;
    end

    // Prescaler next value and registered 1 Hz tick aligned to the last count.
    always_comb begin
        if (sec_clr || (presc_q == PRESC_LAST)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
        tick_d = (presc_d == PRESC_LAST);
    end

    // Mode, prescaler and tick registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is sampled only on the clock edge like any other input.
        if (rst) begin
            mode_q  <= RUN;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    bcd_digit_cnt #(.MAX(SEC_LO_MAX)) u_sec_lo (
        .clk(clk), .rst(rst), .en(run_tick), .clr(sec_clr),
        .value(sec_lo), .co(sec_lo_co)
    );

    bcd_digit_cnt #(.MAX(SEC_HI_MAX)) u_sec_hi (
        .clk(clk), .rst(rst), .en(sec_lo_co), .clr(sec_clr),
        .value(sec_hi), .co(sec_hi_co)
    );

    bcd_digit_cnt #(.MAX(SEC_LO_MAX)) u_min_lo (
        .clk(clk), .rst(rst), .en(min_lo_en), .clr(1'b0),
        .value(min_lo), .co(min_lo_co)
    );

    bcd_digit_cnt #(.MAX(SEC_HI_MAX)) u_min_hi (
        .clk(clk), .rst(rst), .en(min_lo_co), .clr(1'b0),
        .value(min_hi), .co(min_hi_co)
    );

    bcd_digit_cnt #(.MAX(SEC_LO_MAX)) u_hr_lo (
        .clk(clk), .rst(rst), .en(hr_lo_en), .clr(hr_clr),
        .value(hr_lo), .co(hr_lo_co)
    );

    bcd_digit_cnt #(.MAX(HR_MAX_HI)) u_hr_hi (
        .clk(clk), .rst(rst), .en(hr_lo_co), .clr(hr_clr),
        .value(hr_hi), .co(hr_hi_co)
    );

    assign tick_1hz = tick_q;
    assign mode     = mode_q;

`ifdef CLOCK_SET_BLINK_EN
    localparam logic [CNT_W-1:0] PRESC_HALF = CNT_W'(TICK_DIV / 2);
    assign blink = (mode_q != RUN) && (presc_q < PRESC_HALF);
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with TICK_DIV=4: an integer reference model
// predicts every output each cycle through a scoreboard queue, and directed
// checks pin down the key time values.
module tb_clock_set_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick_1hz;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [1:0] mode;
    logic       blink;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] hr_hi;
        logic [3:0] hr_lo;
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [3:0] sec_hi;
        logic [3:0] sec_lo;
        logic       tick;
        logic       blink;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state.
    int    m_hh = 0, m_mm = 0, m_ss = 0, m_md = 0, m_presc = 0;
    logic  m_tick = 1'b0;

    clock_set_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .tick_1hz(tick_1hz),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .hr_lo(hr_lo), .hr_hi(hr_hi), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_update(input logic bm, input logic bi, input logic r);
        int pn;
        if (r) begin
            m_hh = 0; m_mm = 0; m_ss = 0; m_md = 0; m_presc = 0; m_tick = 1'b0;
        end else begin
            if (m_md == 0 && m_tick) begin
                m_ss++;
                if (m_ss == 60) begin
                    m_ss = 0;
                    m_mm++;
                    if (m_mm == 60) begin
                        m_mm = 0;
                        m_hh = (m_hh + 1) % 24;
                    end
                end
            end
            if (m_md == 1 && bi && !bm) m_hh = (m_hh + 1) % 24;
            if (m_md == 2 && bi && !bm) m_mm = (m_mm + 1) % 60;
            if (m_md == 2 && bm) begin
                m_ss = 0;
                pn   = 0;
            end else begin
                pn = (m_presc == TD - 1) ? 0 : m_presc + 1;
            end
            m_tick  = (pn == TD - 1);
            m_presc = pn;
            if (bm) m_md = (m_md + 1) % 3;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.mode   = 2'(m_md);
        s.hr_hi  = 4'(m_hh / 10);
        s.hr_lo  = 4'(m_hh % 10);
        s.min_hi = 4'(m_mm / 10);
        s.min_lo = 4'(m_mm % 10);
        s.sec_hi = 4'(m_ss / 10);
        s.sec_lo = 4'(m_ss % 10);
        s.tick   = m_tick;
`ifdef CLOCK_SET_BLINK_EN
        s.blink  = (m_md != 0) && (m_presc < TD / 2);
`else
        s.blink  = 1'b0;
`endif
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.mode   = mode;
        s.hr_hi  = hr_hi;
        s.hr_lo  = hr_lo;
        s.min_hi = min_hi;
        s.min_lo = min_lo;
        s.sec_hi = sec_hi;
        s.sec_lo = sec_lo;
        s.tick   = tick_1hz;
        s.blink  = blink;
        return s;
    endfunction

    // One clock: drive inputs, queue the prediction, then compare after the edge.
    task automatic step(input logic bm, input logic bi, input logic r);
        snap_t want;
        @(negedge clk);
        btn_mode = bm;
        btn_inc  = bi;
        rst      = r;
        model_update(bm, bi, r);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check("cycle", 32'(dut_snap()), 32'(want));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_mode();
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int hi_cnt;
        int s0;

        // Reset and basic seconds counting.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("reset_time", 32'({hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
        check("reset_mode_tick", 32'({mode, tick_1hz, blink}), 32'h0);
        idle(40);
        check("ten_ticks", 32'({sec_hi, sec_lo}), 32'h10);

        // Load 23:59 through the set modes, then run to 23:59:58 and roll over.
        press_mode();
        incs(23);
        press_mode();
        incs(59);
        press_mode();
        check("back_to_run", 32'({mode, sec_hi, sec_lo}), 32'h0);
        idle(58 * TD);
        check("t235958", 32'({hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h235958);
        idle(TD);
        check("t235959", 32'({hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h235959);
        idle(TD - 1);
        check("t235959_hold", 32'({hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h235959);
        idle(1);
        check("rollover", 32'({hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h0);

        // SET_HR: frozen time, BCD hour increments, 23 -> 00.
        press_mode();
        idle(3 * TD);
        check("frozen", 32'({mode, hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h1000000);
        incs(15);
        check("hours_15", 32'({hr_hi, hr_lo}), 32'h15);
        incs(8);
        check("hours_23", 32'({hr_hi, hr_lo}), 32'h23);
        incs(1);
        check("hours_wrap", 32'({hr_hi, hr_lo, min_hi, min_lo}), 32'h0);

        // SET_MIN: 61 increments from 00 give 01 with no carry into hours.
        incs(7);
        press_mode();
        incs(61);
        check("min_61", 32'({mode, hr_hi, hr_lo, min_hi, min_lo}), 32'h20701);
        press_mode();
        check("run_sec_clr", 32'({mode, sec_hi, sec_lo}), 32'h0);
        idle(TD - 2);
        check("no_early_tick", 32'(tick_1hz), 32'h0);
        idle(1);
        check("first_tick", 32'(tick_1hz), 32'h1);
        idle(1);
        check("first_sec", 32'(sec_lo), 32'h1);

        // Simultaneous buttons in SET_HR: mode advances, hours unchanged.
        press_mode();
        step(1'b1, 1'b1, 1'b0);
        check("both_btn", 32'({mode, hr_hi, hr_lo}), 32'h207);

        // Build 12:34 in SET_MIN, then reset mid-set.
        incs(33);
        press_mode();
        press_mode();
        incs(5);
        press_mode();
        check("t1234", 32'({mode, hr_hi, hr_lo, min_hi, min_lo}), 32'h21234);
        step(1'b0, 1'b1, 1'b1);
        check("reset_mid_set", 32'({mode, hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
        step(1'b0, 1'b0, 1'b0);

        // Blink strobe over two prescaler periods in SET_HR.
        press_mode();
        hi_cnt = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (blink === 1'b1) hi_cnt++;
        end
`ifdef CLOCK_SET_BLINK_EN
        check("blink_duty", 32'(hi_cnt), 32'(TD));
`else
        check("blink_off", 32'(hi_cnt), 32'h0);
`endif

        // Back to RUN: no blink, and a tick coinciding with btn_mode is applied.
        press_mode();
        press_mode();
        hi_cnt = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (blink === 1'b1) hi_cnt++;
        end
        check("blink_run", 32'(hi_cnt), 32'h0);
        for (int i = 0; i < TD && !m_tick; i++) step(1'b0, 1'b0, 1'b0);
        s0 = m_ss;
        press_mode();
        check("tick_with_mode", 32'({mode, sec_lo}), 32'({2'd1, 4'(s0 % 10 + 1)}));

        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
